// File: rtl/wb_if.sv
// Writeback stage bus: ALU and LSU result handshakes plus the register file write port.
interface wb_if #(
    parameter int XLEN = 64
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [63:0]     lsu_data;
    logic [2:0]      lsu_funct3;
    logic [2:0]      lsu_off;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            wb_err;

    // Producer side: the execute units feeding results, observing the write port.
    modport master (
        output alu_valid, alu_rd, alu_result,
        output lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_off,
        input  alu_ready, lsu_ready,
        input  rf_we, rf_waddr, rf_wdata, wb_err
    );

    // Writeback stage side.
    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_off,
        output alu_ready, lsu_ready,
        output rf_we, rf_waddr, rf_wdata, wb_err
    );
endinterface

// File: rtl/wb_stage.sv
// RV64I writeback stage: arbitrates ALU/LSU results, extracts and extends load
// data, and drives a registered register-file write port (one write per cycle).
module wb_stage #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    wb_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             alu_pri;
    logic             alu_gnt;
    logic             lsu_gnt;

    logic [XLEN-1:0]  ld_data_p0;
    logic             ld_err_p0;

    logic             rf_we_p1;
    logic [4:0]       rf_waddr_p1;
    logic [XLEN-1:0]  rf_wdata_p1;
    logic             err_p1;

    // Shift the addressed lane down and extend it according to the load type.
    function automatic logic [XLEN-1:0] load_extract(input logic [63:0] data,
                                                     input logic [2:0]  funct3,
                                                     input logic [2:0]  off);
        logic [63:0] lane;
        lane = data >> {off, 3'b000};
        case (funct3)
            3'b000:  return {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  return {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  return {{(XLEN-32){lane[31]}}, lane[31:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, lane[15:0]};
            3'b110:  return {{(XLEN-32){1'b0}}, lane[31:0]};
            default: return lane;
        endcase
    endfunction

    // Illegal encoding (111) or an offset not aligned to the access size.
    function automatic logic load_bad(input logic [2:0] funct3,
                                      input logic [2:0] off);
        logic bad;
        bad = 1'b0;
        if (funct3 == 3'b111) begin
            bad = 1'b1;
        end else begin
            case (funct3[1:0])
                2'b01:   bad = off[0];
                2'b10:   bad = |off[1:0];
                2'b11:   bad = |off;
                default: bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

    // Grant: LSU wins unless it is idle or the ALU has been starved long enough.
    always_comb begin
        alu_pri = bus.alu_valid && (!bus.lsu_valid || (starve_cnt == STARVE_LIM));
        alu_gnt = rst_n && alu_pri;
        lsu_gnt = rst_n && bus.lsu_valid && !alu_pri;
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;

    // Stage 0: load lane extraction and error detection.
    always_comb begin
        ld_data_p0 = load_extract(bus.lsu_data, bus.lsu_funct3, bus.lsu_off);
        ld_err_p0  = load_bad(bus.lsu_funct3, bus.lsu_off);
    end

    // Count consecutive cycles a pending ALU result loses arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.alu_valid || alu_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Stage 1: register the accepted result onto the write port; x0 and faulting loads do not write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_p1    <= 1'b0;
            rf_waddr_p1 <= '0;
            rf_wdata_p1 <= '0;
            err_p1      <= 1'b0;
        end else begin
            rf_we_p1 <= 1'b0;
            err_p1   <= 1'b0;
            if (alu_gnt) begin
                if (bus.alu_rd != 5'd0) begin
                    rf_we_p1    <= 1'b1;
                    rf_waddr_p1 <= bus.alu_rd;
                    rf_wdata_p1 <= bus.alu_result;
                end
            end else if (lsu_gnt) begin
                if (ld_err_p0) begin
                    err_p1 <= 1'b1;
                end else if (bus.lsu_rd != 5'd0) begin
                    rf_we_p1    <= 1'b1;
                    rf_waddr_p1 <= bus.lsu_rd;
                    rf_wdata_p1 <= ld_data_p0;
                end
            end
        end
    end

    assign bus.rf_we    = rf_we_p1;
    assign bus.rf_waddr = rf_waddr_p1;
    assign bus.rf_wdata = rf_wdata_p1;
    assign bus.wb_err   = err_p1;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver pushes the hand-computed write-port
// result for every issued cycle, a monitor pops and compares one cycle later.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_if #(.XLEN(64)) bus ();

    wb_stage #(.XLEN(64), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [63:0] LDATA = 64'h8899AABBCCDDEEFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t ew(input logic [4:0] rd, input logic [63:0] d);
        exp_t e;
        e.we = 1'b1; e.waddr = rd; e.wdata = d; e.err = 1'b0;
        return e;
    endfunction

    function automatic exp_t en();
        exp_t e;
        e.we = 1'b0; e.waddr = '0; e.wdata = '0; e.err = 1'b0;
        return e;
    endfunction

    function automatic exp_t ee();
        exp_t e;
        e.we = 1'b0; e.waddr = '0; e.wdata = '0; e.err = 1'b1;
        return e;
    endfunction

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [63:0] res);
        bus.alu_valid  = v;
        bus.alu_rd     = rd;
        bus.alu_result = res;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [63:0] d,
                           input logic [2:0] f3, input logic [2:0] off);
        bus.lsu_valid  = v;
        bus.lsu_rd     = rd;
        bus.lsu_data   = d;
        bus.lsu_funct3 = f3;
        bus.lsu_off    = off;
    endtask

    // One cycle with the current inputs: check grants, queue the expected write.
    task automatic step(input logic ea, input logic el, input exp_t e);
        @(negedge clk);
        chk("alu_ready", {63'd0, bus.alu_ready}, {63'd0, ea});
        chk("lsu_ready", {63'd0, bus.lsu_ready}, {63'd0, el});
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the write port just after each edge against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", {63'd0, bus.rf_we}, {63'd0, e.we});
                chk("wb_err", {63'd0, bus.wb_err}, {63'd0, e.err});
                if (e.we) begin
                    chk("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, e.waddr});
                    chk("rf_wdata", bus.rf_wdata, e.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end required end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        set_alu(1'b0, 5'd0, 64'd0);
        set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);

        // Reset state with requests pending.
        repeat (2) @(posedge clk);
        #1;
        set_alu(1'b1, 5'd3, 64'h1234);
        set_lsu(1'b1, 5'd1, LDATA, 3'b011, 3'd0);
        #1;
        chk("rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 64'd0);
        chk("rst_alu_ready", {63'd0, bus.alu_ready}, 64'd0);
        chk("rst_lsu_ready", {63'd0, bus.lsu_ready}, 64'd0);
        chk("rst_wb_err", {63'd0, bus.wb_err}, 64'd0);
        set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, ew(5'd3, 64'h1234));
        set_alu(1'b0, 5'd0, 64'd0);
        step(1'b0, 1'b0, en());

        // Asynchronous reset mid-cycle, right after a write.
        set_alu(1'b1, 5'd4, 64'h55);
        step(1'b1, 1'b0, ew(5'd4, 64'h55));
        set_lsu(1'b1, 5'd6, LDATA, 3'b011, 3'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
        chk("async_rst_rf_wdata", bus.rf_wdata, 64'd0);
        chk("async_rst_alu_ready", {63'd0, bus.alu_ready}, 64'd0);
        chk("async_rst_lsu_ready", {63'd0, bus.lsu_ready}, 64'd0);
        set_alu(1'b0, 5'd0, 64'd0);
        set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load extraction and extension.
        set_lsu(1'b1, 5'd5, LDATA, 3'b000, 3'd1);
        step(1'b0, 1'b1, ew(5'd5, 64'hFFFFFFFFFFFFFFEE));
        set_lsu(1'b1, 5'd5, LDATA, 3'b100, 3'd1);
        step(1'b0, 1'b1, ew(5'd5, 64'h00000000000000EE));
        set_lsu(1'b1, 5'd5, LDATA, 3'b010, 3'd4);
        step(1'b0, 1'b1, ew(5'd5, 64'hFFFFFFFF8899AABB));
        set_lsu(1'b1, 5'd5, LDATA, 3'b110, 3'd4);
        step(1'b0, 1'b1, ew(5'd5, 64'h000000008899AABB));
        set_lsu(1'b1, 5'd5, LDATA, 3'b011, 3'd0);
        step(1'b0, 1'b1, ew(5'd5, 64'h8899AABBCCDDEEFF));
        set_lsu(1'b1, 5'd8, LDATA, 3'b001, 3'd2);
        step(1'b0, 1'b1, ew(5'd8, 64'hFFFFFFFFFFFFCCDD));
        set_lsu(1'b1, 5'd8, LDATA, 3'b101, 3'd6);
        step(1'b0, 1'b1, ew(5'd8, 64'h0000000000008899));
        set_lsu(1'b1, 5'd8, LDATA, 3'b000, 3'd7);
        step(1'b0, 1'b1, ew(5'd8, 64'hFFFFFFFFFFFFFF88));
        set_lsu(1'b1, 5'd8, 64'h0000000000007F00, 3'b000, 3'd1);
        step(1'b0, 1'b1, ew(5'd8, 64'h000000000000007F));

        // Misaligned and illegal loads are consumed and flagged.
        set_lsu(1'b1, 5'd7, LDATA, 3'b001, 3'd3);
        step(1'b0, 1'b1, ee());
        set_lsu(1'b1, 5'd7, LDATA, 3'b111, 3'd0);
        step(1'b0, 1'b1, ee());
        set_lsu(1'b1, 5'd7, LDATA, 3'b011, 3'd4);
        step(1'b0, 1'b1, ee());
        set_lsu(1'b1, 5'd7, LDATA, 3'b110, 3'd2);
        step(1'b0, 1'b1, ee());
        set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);
        step(1'b0, 1'b0, en());

        // x0 destinations are accepted without a write.
        set_alu(1'b1, 5'd0, 64'hDEADBEEFDEADBEEF);
        step(1'b1, 1'b0, en());
        set_alu(1'b0, 5'd0, 64'd0);
        set_lsu(1'b1, 5'd0, LDATA, 3'b011, 3'd0);
        step(1'b0, 1'b1, en());
        set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);
        step(1'b0, 1'b0, en());

        // Starvation: four LSU grants, then the ALU, then the LSU resumes.
        set_alu(1'b1, 5'd9, 64'h9999);
        k = 0;
        for (int c = 0; c < 7; c++) begin
            set_lsu(1'b1, 5'(10 + k), 64'h1111111111111111 * 64'(k + 1), 3'b011, 3'd0);
            if (c == 4) begin
                step(1'b1, 1'b0, ew(5'd9, 64'h9999));
                set_alu(1'b0, 5'd0, 64'd0);
            end else begin
                step(1'b0, 1'b1, ew(5'(10 + k), 64'h1111111111111111 * 64'(k + 1)));
                k++;
            end
        end
        set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);
        step(1'b0, 1'b0, en());

        // Back-to-back alternating single-source results.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);
                set_alu(1'b1, 5'(i + 1), 64'hA5A5000000000000 + 64'(i));
                step(1'b1, 1'b0, ew(5'(i + 1), 64'hA5A5000000000000 + 64'(i)));
            end else begin
                set_alu(1'b0, 5'd0, 64'd0);
                set_lsu(1'b1, 5'(i + 1), 64'h0101010101010101 * 64'(i), 3'b011, 3'd0);
                step(1'b0, 1'b1, ew(5'(i + 1), 64'h0101010101010101 * 64'(i)));
            end
        end
        set_alu(1'b0, 5'd0, 64'd0);
        set_lsu(1'b0, 5'd0, 64'd0, 3'b000, 3'd0);
        step(1'b0, 1'b0, en());

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
